// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin front end that time-shares one FP_Div
// Newton-Raphson divider between NUM_REQ requesters. One operation is in
// flight at a time: accept, start the divider, wait for its stall to drop,
// then hold the quotient for the owner until it is consumed.
//
// Handshake rule (both request and response sides): a transfer happens on a
// rising clock edge where valid and ready are both high. Valid does not
// depend on ready. The arbiter's req_ready/resp_valid are decoded from state
// only (plus the round-robin winner), and a requester may withdraw
// req_valid before it is granted.
module fp_div_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_numA,
  input  logic [32*NUM_REQ-1:0] req_numB,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_result,
  output logic [IDW-1:0]        resp_id,
  output logic                  arb_busy,
  output logic                  div_start,
  output logic [31:0]           div_numA,
  output logic [31:0]           div_numB,
  input  logic                  div_stall,
  input  logic [31:0]           div_result,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_last_grant;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_winner;
  logic           w_any;
  logic           w_accept;
  logic           w_resp_done;
  logic [31:0]    r_num_a;
  logic [31:0]    r_num_b;
  logic [31:0]    r_result;

  // Round-robin search: first valid requester above the last completed owner.
  always_comb begin
    logic [IDW:0] idx_w;
    idx_w    = '0;
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_w = {1'b0, r_last_grant} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NUM_REQ)) begin
        idx_w = idx_w - (IDW+1)'(NUM_REQ);
      end
      if (!w_any && req_valid[idx_w[IDW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = idx_w[IDW-1:0];
      end
    end
  end

  assign w_accept    = (r_state == S_IDLE) && w_any;
  assign w_resp_done = (r_state == S_RESP) && resp_ready[r_owner];

  // State register.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    div_start   = 1'b0;
    arb_busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          req_ready[w_winner] = 1'b1;
          w_state_nxt         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        if (div_stall) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (!div_stall) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid[r_owner] = 1'b1;
        if (resp_ready[r_owner]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand, owner, quotient and round-robin pointer registers.
  // Operands move only on an accept: the divider reads them combinationally
  // until it registers its own result.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      r_num_a      <= '0;
      r_num_b      <= '0;
      r_owner      <= '0;
      r_result     <= '0;
      r_last_grant <= IDW'(NUM_REQ-1);
    end else begin
      if (w_accept) begin
        r_num_a <= req_numA[{w_winner, 5'd0} +: 32];
        r_num_b <= req_numB[{w_winner, 5'd0} +: 32];
        r_owner <= w_winner;
      end
      if ((r_state == S_BUSY) && !div_stall) begin
        r_result <= div_result;
      end
      if (w_resp_done) begin
        r_last_grant <= r_owner;
      end
    end
  end

  assign div_numA    = r_num_a;
  assign div_numB    = r_num_b;
  assign resp_result = r_result;
  assign resp_id     = r_owner;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a behavioural FP_Div stand-in.
module tb_fp_div_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [32*N-1:0]  req_numA;
  logic [32*N-1:0]  req_numB;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready;
  logic [31:0]      resp_result;
  logic [IDW-1:0]   resp_id;
  logic             arb_busy;
  logic             div_start;
  logic [31:0]      div_numA;
  logic [31:0]      div_numB;
  logic             div_stall;
  logic [31:0]      div_result;
  logic [1:0]       dbg_state;

  int               n_checks;
  int               n_errors;
  int               cyc;
  int               acc_cyc;
  int               n_rise;
  logic [N-1:0]     keep;
  logic [N-1:0]     prev_rv;
  logic [31:0]      exp_res [N];
  logic [33:0]      exp_q[$];
  int               g_id[$];
  int               g_cyc[$];

  fp_div_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .in_Clk      (clk),
    .in_Rst_N    (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_numA    (req_numA),
    .req_numB    (req_numB),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id),
    .arb_busy    (arb_busy),
    .div_start   (div_start),
    .div_numA    (div_numA),
    .div_numB    (div_numB),
    .div_stall   (div_stall),
    .div_result  (div_result),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- divider stand-in ----------------
  // Quotients for the directed operand pairs, worked out by hand.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: return 32'h40400000;
      64'h41000000_3F800000: return 32'h41000000;
      64'h41000000_40000000: return 32'h40800000;
      64'h41000000_40800000: return 32'h40000000;
      64'h41000000_41000000: return 32'h3F800000;
      64'h3F800000_00000000: return 32'h7F800000;
      64'h00000000_00000000: return 32'h7FC00000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // Stall high for four cycles starting the cycle after start is seen.
  logic [2:0]  d_cnt;
  logic [31:0] d_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_cnt      <= '0;
      d_q        <= '0;
      div_stall  <= 1'b0;
      div_result <= '0;
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 3'd1;
      if (d_cnt == 3'd1) begin
        div_stall  <= 1'b0;
        div_result <= d_q;
      end
    end else if (div_start) begin
      d_cnt      <= 3'd4;
      div_stall  <= 1'b1;
      div_result <= 32'hDEADBEEF;
      d_q        <= ref_div(div_numA, div_numB);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [33:0] sb_e;
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if ((req_valid & req_ready) != 0) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            exp_q.push_back({2'(i), exp_res[i]});
            g_id.push_back(i);
            g_cyc.push_back(cyc);
            acc_cyc = cyc;
          end
        end
      end
      if (resp_valid != 0 && prev_rv == 0) begin
        n_rise++;
        check("latency", 32'(cyc - acc_cyc), 32'd7);
      end
      if ((resp_valid & resp_ready) != 0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {28'd0, resp_valid}, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_id", {30'd0, resp_id}, {30'd0, sb_e[33:32]});
          check("sb_onehot", {28'd0, resp_valid}, 32'd1 << sb_e[33:32]);
          check("sb_result", resp_result, sb_e[31:0]);
        end
      end
    end
    prev_rv = resp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q);
    req_numA[32*i +: 32] = a;
    req_numB[32*i +: 32] = b;
    exp_res[i]           = q;
  endtask

  // Advance one cycle; requesters not in keep drop valid after being accepted.
  task automatic step();
    logic [N-1:0] acc;
    acc = req_valid & req_ready & ~keep;
    @(negedge clk);
    req_valid = req_valid & ~acc;
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    logic done;
    done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      step();
      if (req_valid == 0 && !arb_busy && exp_q.size() == 0) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int   base;
    logic got_it;
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    acc_cyc    = 0;
    n_rise     = 0;
    prev_rv    = '0;
    keep       = '0;
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    req_numA   = '0;
    req_numB   = '0;
    for (int i = 0; i < N; i++) exp_res[i] = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    check("rst_div_start", {31'd0, div_start}, 32'd0);
    check("rst_busy", {31'd0, arb_busy}, 32'd0);
    check("rst_result", resp_result, 32'd0);
    check("rst_numA", div_numA, 32'd0);
    check("rst_numB", div_numB, 32'd0);
    check("rst_id", {30'd0, resp_id}, 32'd0);
    rst_n = 1'b1;
    step();

    // Contention: all four at once, grants 0,1,2,3 eight cycles apart
    set_req(0, 32'h41000000, 32'h3F800000, 32'h41000000);
    set_req(1, 32'h41000000, 32'h40000000, 32'h40800000);
    set_req(2, 32'h41000000, 32'h40800000, 32'h40000000);
    set_req(3, 32'h41000000, 32'h41000000, 32'h3F800000);
    base      = g_id.size();
    req_valid = 4'b1111;
    #1;
    check("cont_first_ready", {28'd0, req_ready}, 32'h1);
    drain("cont_done", 80);
    check("cont_grants", 32'(g_id.size() - base), 32'd4);
    if (g_id.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("cont_order", 32'(g_id[base+k]), 32'(k));
        if (k > 0) check("cont_spacing", 32'(g_cyc[base+k] - g_cyc[base+k-1]), 32'd8);
      end
    end

    // Fairness: requesters 0 and 2 request continuously
    set_req(0, 32'h41000000, 32'h3F800000, 32'h41000000);
    set_req(2, 32'h41000000, 32'h40800000, 32'h40000000);
    base      = g_id.size();
    keep      = 4'b0101;
    req_valid = 4'b0101;
    got_it    = 1'b0;
    for (int c = 0; c < 60 && !got_it; c++) begin
      step();
      if (g_id.size() >= base + 4) got_it = 1'b1;
    end
    keep      = '0;
    req_valid = '0;
    check("fair_reached", {31'd0, got_it}, 32'd1);
    if (got_it) begin
      for (int k = 0; k < 4; k++) begin
        check("fair_order", 32'(g_id[base+k]), (k % 2 == 0) ? 32'd0 : 32'd2);
        if (k > 0) check("fair_wait", 32'(g_cyc[base+k] - g_cyc[base+k-1]), 32'd8);
      end
    end
    drain("fair_drain", 40);

    // Single op cycle by cycle: requester 1, 6.0 / 2.0
    set_req(1, 32'h40C00000, 32'h40000000, 32'h40400000);
    req_valid = 4'b0010;
    #1;
    check("t1_ready", {28'd0, req_ready}, 32'h2);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t1_start", {31'd0, div_start}, (k == 1 || k == 2) ? 32'd1 : 32'd0);
      if (k == 1) begin
        check("t1_numA", div_numA, 32'h40C00000);
        check("t1_numB", div_numB, 32'h40000000);
        check("t1_busy", {31'd0, arb_busy}, 32'd1);
      end
      if (k < 7) check("t1_no_resp", {28'd0, resp_valid}, 32'd0);
      if (k == 7) begin
        check("t1_resp_valid", {28'd0, resp_valid}, 32'h2);
        check("t1_resp_id", {30'd0, resp_id}, 32'd1);
        check("t1_resp_result", resp_result, 32'h40400000);
      end
      if (k == 8) check("t1_idle", {31'd0, arb_busy}, 32'd0);
    end

    // Backpressure: requester 0 result held 10 cycles while requester 3 waits
    resp_ready = '0;
    set_req(0, 32'h41000000, 32'h3F800000, 32'h41000000);
    req_valid = 4'b0001;
    #1;
    check("bp_ready0", {28'd0, req_ready}, 32'h1);
    step();
    set_req(3, 32'h3F800000, 32'h00000000, 32'h7F800000);
    req_valid[3] = 1'b1;
    for (int c = 0; c < 20 && resp_valid == 0; c++) step();
    check("bp_seen", {28'd0, resp_valid}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      check("bp_result", resp_result, 32'h41000000);
      check("bp_id", {30'd0, resp_id}, 32'd0);
      check("bp_no_ready", {28'd0, req_ready}, 32'd0);
      step();
    end
    resp_ready = '1;
    #1;
    step();
    check("bp_next_grant", {28'd0, req_ready}, 32'h8);
    drain("bp_drain", 40);

    // Special values pass through unmodified
    set_req(2, 32'h00000000, 32'h00000000, 32'h7FC00000);
    req_valid = 4'b0100;
    drain("sp_nan", 40);
    set_req(1, 32'h3F800000, 32'h00000000, 32'h7F800000);
    req_valid = 4'b0010;
    drain("sp_inf", 40);

    // Reset while BUSY, then a fresh request from 0 wins over 2
    set_req(1, 32'h40C00000, 32'h40000000, 32'h40400000);
    req_valid = 4'b0010;
    #1;
    for (int k = 1; k <= 4; k++) step();
    check("rst_pre_busy", {30'd0, dbg_state}, 32'd2);
    base  = n_rise;
    rst_n = 1'b0;
    exp_q.delete();
    req_valid = '0;
    #1;
    check("mid_req_ready", {28'd0, req_ready}, 32'd0);
    check("mid_resp_valid", {28'd0, resp_valid}, 32'd0);
    check("mid_div_start", {31'd0, div_start}, 32'd0);
    check("mid_busy", {31'd0, arb_busy}, 32'd0);
    check("mid_result", resp_result, 32'd0);
    check("mid_numA", div_numA, 32'd0);
    check("mid_numB", div_numB, 32'd0);
    check("mid_id", {30'd0, resp_id}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("mid_no_resp", 32'(n_rise), 32'(base));
    set_req(0, 32'h41000000, 32'h40000000, 32'h40800000);
    set_req(2, 32'h41000000, 32'h41000000, 32'h3F800000);
    req_valid = 4'b0101;
    #1;
    check("mid_first_ready", {28'd0, req_ready}, 32'h1);
    drain("mid_drain", 60);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin arbiter and sequencer that shares one `FP_Div` Newton-Raphson divider between `NUM_REQ` requesters. It accepts single-precision operand pairs over per-requester valid/ready handshakes and holds the winner's operands stable on the divider. It drives the divider's start/stall protocol and returns the registered quotient to the owning requester over a valid/ready response handshake. It sits between the FP compute clients and the single divider instance; the divider's ports connect directly to the `div_*` ports.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..8 supported.
- `IDW`, default 2: width of `resp_id`, equal to clog2(`NUM_REQ`).
- `in_Clk`  in  1  clock; all logic is rising-edge.
- `in_Rst_N`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_numA`  in  32*NUM_REQ  dividend; requester i uses bits [32i+31:32i].
- `req_numB`  in  32*NUM_REQ  divisor; same slicing as `req_numA`.
- `resp_valid`  out  NUM_REQ  one-hot result valid to the owner.
- `resp_ready`  in  NUM_REQ  per-requester result accept.
- `resp_result`  out  32  quotient; meaningful only while `resp_valid` is nonzero.
- `resp_id`  out  IDW  index of the owner of the current response.
- `arb_busy`  out  1  high whenever the state is not IDLE.
- `div_start`  out  1  connects to the divider `in_start`.
- `div_numA`, `div_numB`  out  32 each  connect to the divider `in_numA` and `in_numB`; registered and held stable.
- `div_stall`  in  1  connects to the divider `out_stall`.
- `div_result`  in  32  connects to the divider `out_result`.

## Operation
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Winner = first set `req_valid` bit found by searching upward from `last_grant+1`, modulo `NUM_REQ`.
  - `req_ready[winner]`=1, decoded combinationally from state and winner.
  - On `req_valid & req_ready`: latch A and B into `div_numA`/`div_numB`, latch the winner into `owner`, then go to ISSUE.
- ISSUE:
  - `div_start`=1, decoded from state.
  - Stay in ISSUE until `div_stall` is sampled 1, then go to BUSY.
- BUSY:
  - `div_start`=0.
  - When `div_stall` is sampled 0, capture `div_result` into the result register and go to RESP.
- RESP:
  - `resp_valid[owner]`=1, `resp_id`=`owner`, `resp_result`=captured value.
  - On `resp_ready[owner]`: `last_grant`<=`owner`, go to IDLE.
  - `resp_ready` bits of non-owners are ignored.
- `req_ready` is all-zero outside IDLE.
- `div_numA`/`div_numB` change only on an accept, because the divider's combinational datapath reads them until its result is registered.
- No new request is accepted until the response is consumed; the block runs one operation at a time.
- Requesters hold `req_valid` and the operands until `req_ready`. Dropping `req_valid` before grant is legal and simply withdraws the request.
- The quotient (including NaN, Inf and zero results) is passed through unmodified. The block performs no FP arithmetic.

## Timing
- Reset values:
  - State IDLE; `req_ready`, `resp_valid`, `div_start`, `arb_busy` all 0.
  - `resp_result`, `div_numA`, `div_numB` are 0; `resp_id` is 0.
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
- Accept in cycle T; ISSUE in T+1.
- Divider `out_stall` is high from T+2 through T+5, so BUSY runs T+3..T+6.
- Stall low is sampled in T+6; `resp_valid` is asserted in T+7, for an accept-to-response latency of 7 cycles.
- With `resp_ready` held high, IDLE is in T+8 and the next accept can occur in T+8: 8 cycles per operation.
- Backpressure:
  - `resp_ready` low holds RESP, with `resp_result` and `resp_id` stable and all `req_ready` at 0, for as long as required.
  - There is no timeout.
- Simultaneous requests: exactly one grant per IDLE cycle, following the round-robin rule. The pointer advances only when a response completes.
- A request arriving in the same cycle as the RESP-to-IDLE transition is arbitrated in the following IDLE cycle.
- Reset mid-operation (any state):
  - Immediate return to the reset values; the in-flight operation is discarded and no response is issued.
  - The divider shares `in_Rst_N` and resets with the arbiter.

## Test plan
- Single op: requester 1 sends A=0x40C00000 (6.0), B=0x40000000 (2.0), accepted at T. Expect `resp_valid`=0b0010, `resp_id`=1, `resp_result`=0x40400000 in T+7, and `div_start` high only in T+1..T+2.
- Contention: all four `req_valid` asserted together, each requester dividing 8.0 by its own divisor (1.0, 2.0, 4.0, 8.0), with `resp_ready` always high. Expect grants in order 0, 1, 2, 3, 8 cycles apart, with results 0x41000000, 0x40800000, 0x40000000, 0x3F800000.
- Fairness: requesters 0 and 2 issue back-to-back requests continuously. Expect grants to alternate 0, 2, 0, 2, and neither requester waits more than one operation.
- Backpressure: hold `resp_ready` low for 10 cycles after `resp_valid` rises, while requester 3 keeps `req_valid` high. Expect `resp_result` stable and `req_ready`=0 throughout; requester 3 is accepted in the first IDLE cycle after the handshake.
- Special values: 1.0/0.0 gives 0x7F800000; 0.0/0.0 gives 0x7FC00000. Both complete with the standard 7-cycle latency.
- Reset in BUSY: pulse `in_Rst_N` low at T+4. Expect all outputs at their reset values, no `resp_valid`, and a fresh request to requester 0 completing normally afterwards.
